// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: enables/flushes for the IF/ID, ID/EX, EX/MEM and MEM/WB
// pipeline registers and the PC. Handles load-use bubbles, redirects resolved in
// MEM, and multi-cycle data-memory accesses with a timeout watchdog.
// Optional build macro: HAZARD_PERF_CNT_EN enables the three performance counters;
// without it the counter outputs are tied to zero and no counter flops exist.
module pipeline_hazard_ctrl #(
    parameter int REG_ADDR_W  = 5,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  id_ex_memread,
    input  logic [REG_ADDR_W-1:0] id_ex_rd,
    input  logic [REG_ADDR_W-1:0] if_id_rs1,
    input  logic [REG_ADDR_W-1:0] if_id_rs2,
    input  logic                  ex_mem_redirect,
    input  logic                  mem_req,
    input  logic                  mem_ack,
    output logic                  pc_en,
    output logic                  if_id_en,
    output logic                  id_ex_en,
    output logic                  ex_mem_en,
    output logic                  mem_wb_en,
    output logic                  if_id_flush,
    output logic                  id_ex_flush,
    output logic                  ex_mem_flush,
    output logic                  mem_err,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      flush_events,
    output logic [CNT_W-1:0]      load_use_events
);

    localparam logic [1:0] ST_RUN  = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_ERR  = 2'd2;

    // The watchdog limit widened by one bit so the incremented count cannot wrap.
    localparam logic [16:0] TMO_LIMIT = 17'(MEM_TIMEOUT);

    logic [1:0]  state_q, state_d;
    logic [15:0] tmo_q, tmo_d;
    logic        mem_err_q, mem_err_d;
    logic [16:0] tmo_inc;
    logic        load_use;
    logic        run_eval;

    assign load_use = id_ex_memread && (id_ex_rd != '0) &&
                      ((id_ex_rd == if_id_rs1) || (id_ex_rd == if_id_rs2));
    assign tmo_inc  = {1'b0, tmo_q} + 17'd1;
    assign mem_err  = mem_err_q;

    // Next-state logic and combinational enable/flush generation.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
        state_d      = state_q;
        tmo_d        = tmo_q;
        mem_err_d    = mem_err_q;
        run_eval     = 1'b0;
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        id_ex_en     = 1'b1;
        ex_mem_en    = 1'b1;
        mem_wb_en    = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (mem_req && !mem_ack) begin
                    {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '0;
                    state_d = ST_WAIT;
                    tmo_d   = 16'd1;
                end else begin
                    run_eval = 1'b1;
                end
            end
            ST_WAIT: begin
                if (mem_ack) begin
                    // Ack beats timeout; the ack cycle services redirect/load-use.
                    state_d  = ST_RUN;
                    tmo_d    = '0;
                    run_eval = 1'b1;
                end else begin
                    {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '0;
                    if (tmo_inc >= TMO_LIMIT) begin
                        state_d   = ST_ERR;
                        mem_err_d = 1'b1;
                    end else begin
                        tmo_d = tmo_inc[15:0];
                    end
                end
            end
            default: begin
                // MEM_ERR (and any illegal encoding) freezes the pipeline until reset.
                {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '0;
            end
        endcase

        if (run_eval) begin
            if (ex_mem_redirect) begin
                // A load-use in the same cycle is moot: its instruction is flushed.
                {if_id_flush, id_ex_flush, ex_mem_flush} = 3'b111;
            end else if (load_use) begin
                pc_en       = 1'b0;
                if_id_en    = 1'b0;
                id_ex_flush = 1'b1;
            end
        end

        // While reset is held the pipeline registers free-run with no flushes.
        if (!arst_n) begin
            {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '1;
            {if_id_flush, id_ex_flush, ex_mem_flush}          = '0;
        end
    end

    // FSM state, watchdog count and sticky error flag.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every flop sampling pre-edge values regardless of statement order.
        if (!arst_n) begin
            state_q   <= ST_RUN;
            tmo_q     <= '0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmo_q     <= tmo_d;
            mem_err_q <= mem_err_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0] flush_events_q, flush_events_d;
    logic [CNT_W-1:0] load_use_events_q, load_use_events_d;

    // Counter increments derived from the serviced enables/flushes; all wrap.
    always_comb begin
        stall_cycles_d    = stall_cycles_q;
        flush_events_d    = flush_events_q;
        load_use_events_d = load_use_events_q;
        if (!pc_en && (state_q != ST_ERR)) stall_cycles_d    = stall_cycles_q + CNT_W'(1);
        if (if_id_flush)                   flush_events_d    = flush_events_q + CNT_W'(1);
        if (id_ex_flush && !if_id_flush)   load_use_events_d = load_use_events_q + CNT_W'(1);
    end

    // Performance counter registers.
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            stall_cycles_q    <= '0;
            flush_events_q    <= '0;
            load_use_events_q <= '0;
        end else begin
            stall_cycles_q    <= stall_cycles_d;
            flush_events_q    <= flush_events_d;
            load_use_events_q <= load_use_events_d;
        end
    end

    assign stall_cycles    = stall_cycles_q;
    assign flush_events    = flush_events_q;
    assign load_use_events = load_use_events_q;
`else
    assign stall_cycles    = '0;
    assign flush_events    = '0;
    assign load_use_events = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed, table-driven bench for pipeline_hazard_ctrl (MEM_TIMEOUT = 8).
module tb_pipeline_hazard_ctrl;

    localparam int CNT_W = 32;

    // Output vector order: {pc, if_id, id_ex, ex_mem, mem_wb enables, if_id, id_ex, ex_mem flushes}
    localparam logic [7:0] V_RUN   = 8'b11111_000;
    localparam logic [7:0] V_STALL = 8'b00000_000;
    localparam logic [7:0] V_LU    = 8'b00111_010;
    localparam logic [7:0] V_RED   = 8'b11111_111;

    logic clk = 1'b0;
    logic arst_n;
    logic id_ex_memread, ex_mem_redirect, mem_req, mem_ack;
    logic [4:0] id_ex_rd, if_id_rs1, if_id_rs2;
    logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic if_id_flush, id_ex_flush, ex_mem_flush, mem_err;
    logic [CNT_W-1:0] stall_cycles, flush_events, load_use_events;
    logic [7:0] outs;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_stall = 0, exp_flush = 0, exp_lu = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.REG_ADDR_W(5), .MEM_TIMEOUT(8), .CNT_W(CNT_W)) dut (
        .clk(clk), .arst_n(arst_n),
        .id_ex_memread(id_ex_memread), .id_ex_rd(id_ex_rd),
        .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2),
        .ex_mem_redirect(ex_mem_redirect), .mem_req(mem_req), .mem_ack(mem_ack),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
        .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
        .mem_err(mem_err), .stall_cycles(stall_cycles),
        .flush_events(flush_events), .load_use_events(load_use_events)
    );

    assign outs = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                   if_id_flush, id_ex_flush, ex_mem_flush};

    typedef struct {
        logic       mr;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       red;
        logic       req;
        logic       ack;
        logic [7:0] exp;
        string      name;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic red, input logic req, input logic ack);
        id_ex_memread = mr; id_ex_rd = rd; if_id_rs1 = rs1; if_id_rs2 = rs2;
        ex_mem_redirect = red; mem_req = req; mem_ack = ack;
    endtask

    // Apply one cycle of inputs, compare outputs mid-cycle, then advance past the edge.
    task automatic step(input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic red, input logic req, input logic ack,
                        input logic [7:0] exp, input logic in_err, input string name);
        drive(mr, rd, rs1, rs2, red, req, ack);
        #1;
        check(name, {24'd0, outs}, {24'd0, exp});
        if (!in_err && !exp[7])         exp_stall++;
        if (exp[2:0] == 3'b111)         exp_flush++;
        if (exp[1] && !exp[2])          exp_lu++;
        @(posedge clk);
        #1;
    endtask

    task automatic check_cnt(input string name);
`ifdef HAZARD_PERF_CNT_EN
        check({name, "_stall"}, stall_cycles,    exp_stall);
        check({name, "_flush"}, flush_events,    exp_flush);
        check({name, "_lu"},    load_use_events, exp_lu);
`else
        check({name, "_stall"}, stall_cycles,    32'd0);
        check({name, "_flush"}, flush_events,    32'd0);
        check({name, "_lu"},    load_use_events, 32'd0);
`endif
    endtask

    task automatic clear_exp();
        exp_stall = 0; exp_flush = 0; exp_lu = 0;
    endtask

    initial begin
        //            mr    rd     rs1    rs2    red   req   ack   exp      name
        vecs[0]  = '{1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, V_RUN,   "idle"};
        vecs[1]  = '{1'b1, 5'd5,  5'd1,  5'd5,  1'b0, 1'b0, 1'b0, V_LU,    "lu_rs2"};
        vecs[2]  = '{1'b1, 5'd5,  5'd5,  5'd2,  1'b0, 1'b0, 1'b0, V_LU,    "lu_rs1"};
        vecs[3]  = '{1'b1, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, V_RUN,   "lu_x0"};
        vecs[4]  = '{1'b0, 5'd5,  5'd5,  5'd5,  1'b0, 1'b0, 1'b0, V_RUN,   "no_load"};
        vecs[5]  = '{1'b1, 5'd5,  5'd6,  5'd7,  1'b0, 1'b0, 1'b0, V_RUN,   "no_match"};
        vecs[6]  = '{1'b1, 5'd5,  5'd1,  5'd5,  1'b1, 1'b0, 1'b0, V_RED,   "red_over_lu"};
        vecs[7]  = '{1'b0, 5'd0,  5'd0,  5'd0,  1'b1, 1'b0, 1'b0, V_RED,   "redirect"};
        vecs[8]  = '{1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b1, 1'b1, V_RUN,   "req_ack"};
        vecs[9]  = '{1'b1, 5'd9,  5'd9,  5'd0,  1'b0, 1'b1, 1'b1, V_LU,    "req_ack_lu"};
        vecs[10] = '{1'b1, 5'd31, 5'd3,  5'd31, 1'b0, 1'b0, 1'b0, V_LU,    "lu_r31"};
        vecs[11] = '{1'b0, 5'd0,  5'd0,  5'd0,  1'b1, 1'b1, 1'b1, V_RED,   "req_ack_red"};

        // Reset, with hazard-inducing inputs present to prove the override.
        arst_n = 1'b0;
        drive(1'b1, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_outs", {24'd0, outs}, {24'd0, V_RUN});
        check("reset_mem_err", {31'd0, mem_err}, 32'd0);
        check_cnt("reset");
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        arst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single-cycle RUN behaviour from the vector table.
        for (int i = 0; i < 12; i++)
            step(vecs[i].mr, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].red,
                 vecs[i].req, vecs[i].ack, vecs[i].exp, 1'b0, vecs[i].name);
        check_cnt("table");

        // T1: one bubble, then the load has moved on.
        clear_exp();
        arst_n = 1'b0; @(posedge clk); #1; arst_n = 1'b1;
        step(1'b1, 5'd5, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0, V_LU,  1'b0, "t1_bubble");
        step(1'b0, 5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0, V_RUN, 1'b0, "t1_after");
        check_cnt("t1");

        // T4: four stall cycles, then ack releases the pipeline.
        clear_exp();
        arst_n = 1'b0; @(posedge clk); #1; arst_n = 1'b1;
        for (int i = 0; i < 4; i++)
            step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, V_STALL, 1'b0, "t4_wait");
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, V_RUN, 1'b0, "t4_ack");
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, V_RUN, 1'b0, "t4_run");
        check_cnt("t4");

        // Pending load-use, then pending redirect, serviced in the ack cycle.
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, V_STALL, 1'b0, "ackl_wait");
        step(1'b1, 5'd4, 5'd4, 5'd0, 1'b0, 1'b1, 1'b1, V_LU,    1'b0, "ack_lu");
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, V_STALL, 1'b0, "ackr_wait");
        step(1'b1, 5'd4, 5'd4, 5'd0, 1'b1, 1'b1, 1'b1, V_RED,   1'b0, "ack_red");
        check_cnt("ack_svc");

        // Ack on the same cycle the watchdog would fire: ack wins.
        for (int i = 0; i < 7; i++)
            step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, V_STALL, 1'b0, "edge_wait");
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, V_RUN, 1'b0, "edge_ack");
        check("edge_mem_err", {31'd0, mem_err}, 32'd0);
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, V_RUN, 1'b0, "edge_run");

        // T5: timeout after eight stall cycles, sticky until reset.
        clear_exp();
        arst_n = 1'b0; @(posedge clk); #1; arst_n = 1'b1;
        for (int i = 0; i < 7; i++)
            step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, V_STALL, 1'b0, "t5_wait");
        check("t5_err_pre", {31'd0, mem_err}, 32'd0);
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, V_STALL, 1'b0, "t5_wait8");
        check("t5_err_set", {31'd0, mem_err}, 32'd1);
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, V_STALL, 1'b1, "t5_err_idle");
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, V_STALL, 1'b1, "t5_err_ack");
        check("t5_err_hold", {31'd0, mem_err}, 32'd1);
        check_cnt("t5");
        arst_n = 1'b0;
        @(posedge clk);
        #1;
        check("t5_rst_outs", {24'd0, outs}, {24'd0, V_RUN});
        arst_n = 1'b1;
        clear_exp();
        check("t5_err_clr", {31'd0, mem_err}, 32'd0);
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, V_RUN, 1'b0, "t5_run");
        check_cnt("t5_post");

        // Reset in the middle of MEM_WAIT abandons the access.
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, V_STALL, 1'b0, "mid_wait1");
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, V_STALL, 1'b0, "mid_wait2");
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        arst_n = 1'b0;
        @(posedge clk);
        #1;
        arst_n = 1'b1;
        clear_exp();
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, V_RUN, 1'b0, "mid_rst_run");
        check_cnt("mid_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
